// File: rtl/control_buffer_filas.sv
`default_nettype none
// ============================================================================
// Module      : control_buffer_filas
// Description : Sequencer for the three row FIFOs of a 3x3 filter line
//               buffer. It steers each accepted raster pixel into the row
//               buffer being filled. Once two rows are stored, it pops the two
//               older rows in lock-step with every new pixel. It rotates
//               buffer roles at row ends and flushes the buffers at frame end.
// Ports       : clk, reset (sync, active-high), inicio (start of frame),
//               pixel_valid / pixel_ready (upstream handshake),
//               buf_full / buf_empty (FIFO flags 0..2),
//               buf_write_req / buf_read_req / buf_clear (FIFO controls),
//               sel_escritura (buffer being filled),
//               col / fila (position of the last accepted pixel),
//               ventana_valida (column valid at FIFO outputs),
//               fin_cuadro (end-of-frame pulse), ocupado (not idle),
//               cuenta_stall (stall counter).
// Option      : CTRL_FILAS_CONTADOR_STALL_EN enables the saturating stall
//               counter; when it is undefined, cuenta_stall is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module control_buffer_filas #(
    parameter int ANCHO = 8,
    parameter int ALTO  = 8,
    parameter int CW    = 3,
    parameter int RW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inicio,
    input  logic          pixel_valid,
    output logic          pixel_ready,
    input  logic [2:0]    buf_full,
    input  logic [2:0]    buf_empty,
    output logic [2:0]    buf_write_req,
    output logic [2:0]    buf_read_req,
    output logic          buf_clear,
    output logic [1:0]    sel_escritura,
    output logic [CW-1:0] col,
    output logic [RW-1:0] fila,
    output logic          ventana_valida,
    output logic          fin_cuadro,
    output logic          ocupado,
    output logic [15:0]   cuenta_stall
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_cebado = 2'd1;
    localparam logic [1:0] c_flujo  = 2'd2;
    localparam logic [1:0] c_fin    = 2'd3;

    localparam logic [CW-1:0] c_col_max  = CW'(ANCHO - 1);
    localparam logic [CW-1:0] c_col_uno  = CW'(1);
    localparam logic [RW-1:0] c_fila_max = RW'(ALTO - 1);
    localparam logic [RW-1:0] c_fila_uno = RW'(1);

    logic [1:0]    r_estado;
    logic [1:0]    w_estado_sig;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_mas1;
    logic [1:0]    w_sel_mas2;
    // Position of the pixel about to be accepted; col/fila report the
    // position of the pixel that was last accepted.
    logic [CW-1:0] r_col_pos;
    logic [RW-1:0] r_fila_pos;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_fila;
    logic          r_ventana;
    logic          w_listo;
    logic          w_acepta;
    logic          w_fin_fila;

    // (sel+1)%3 holds the oldest row, (sel+2)%3 the middle row.
    assign w_sel_mas1 = (r_sel == 2'd2) ? 2'd0 : r_sel + 2'd1;
    assign w_sel_mas2 = (r_sel == 2'd0) ? 2'd2 : r_sel - 2'd1;

    always_comb begin
        w_listo = 1'b0;
        case (r_estado)
            c_cebado: w_listo = !buf_full[r_sel];
            c_flujo:  w_listo = !buf_full[r_sel] && !buf_empty[w_sel_mas1]
                                && !buf_empty[w_sel_mas2];
            default:  w_listo = 1'b0;
        endcase
    end

    assign w_acepta   = pixel_valid && w_listo;
    assign w_fin_fila = (r_col_pos == c_col_max);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= c_idle;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            c_idle: begin
                if (inicio) w_estado_sig = c_cebado;
            end
            c_cebado: begin
                if (w_acepta && w_fin_fila && (r_fila_pos == c_fila_uno))
                    w_estado_sig = c_flujo;
            end
            c_flujo: begin
                if (w_acepta && w_fin_fila && (r_fila_pos == c_fila_max))
                    w_estado_sig = c_fin;
            end
            default: w_estado_sig = c_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        buf_write_req = 3'b000;
        buf_read_req  = 3'b000;
        buf_clear     = (r_estado == c_fin);
        fin_cuadro    = (r_estado == c_fin);
        ocupado       = (r_estado != c_idle);
        pixel_ready   = w_listo;
        if (w_acepta) begin
            buf_write_req = 3'b001 << r_sel;
            if (r_estado == c_flujo)
                buf_read_req = (3'b001 << w_sel_mas1) | (3'b001 << w_sel_mas2);
        end
    end

    // ------------------------------------------------------------------
    // Position counters, buffer rotation and window-valid flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || (r_estado == c_fin) || ((r_estado == c_idle) && inicio)) begin
            r_col_pos  <= '0;
            r_fila_pos <= '0;
            r_col      <= '0;
            r_fila     <= '0;
            r_sel      <= 2'd0;
            r_ventana  <= 1'b0;
        end else begin
            // Popped data appears one cycle after the read request.
            r_ventana <= w_acepta && (r_estado == c_flujo);
            if (w_acepta) begin
                r_col  <= r_col_pos;
                r_fila <= r_fila_pos;
                if (w_fin_fila) begin
                    r_col_pos  <= '0;
                    r_fila_pos <= r_fila_pos + c_fila_uno;
                    r_sel      <= w_sel_mas1;
                end else begin
                    r_col_pos  <= r_col_pos + c_col_uno;
                end
            end
        end
    end

    assign sel_escritura  = r_sel;
    assign col            = r_col;
    assign fila           = r_fila;
    assign ventana_valida = r_ventana;

`ifdef CTRL_FILAS_CONTADOR_STALL_EN
    logic [15:0] r_cuenta_stall;

    always_ff @(posedge clk) begin
        if (reset || ((r_estado == c_idle) && inicio)) begin
            r_cuenta_stall <= 16'h0000;
        end else if ((r_estado != c_idle) && pixel_valid && !w_listo
                     && (r_cuenta_stall != 16'hFFFF)) begin
            r_cuenta_stall <= r_cuenta_stall + 16'h0001;
        end
    end

    assign cuenta_stall = r_cuenta_stall;
`else
    assign cuenta_stall = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_buffer_filas.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_buffer_filas
// Description : Self-checking bench for control_buffer_filas (4x4 frame).
//               A reference model tracks how many pixels the frame has
//               accepted and derives the expected row, column, buffer index
//               and requests from that count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_buffer_filas;

    localparam int ANCHO = 4;
    localparam int ALTO  = 4;
    localparam int CW    = 3;
    localparam int RW    = 3;

    logic          clk;
    logic          reset;
    logic          inicio;
    logic          pixel_valid;
    logic          pixel_ready;
    logic [2:0]    buf_full;
    logic [2:0]    buf_empty;
    logic [2:0]    buf_write_req;
    logic [2:0]    buf_read_req;
    logic          buf_clear;
    logic [1:0]    sel_escritura;
    logic [CW-1:0] col;
    logic [RW-1:0] fila;
    logic          ventana_valida;
    logic          fin_cuadro;
    logic          ocupado;
    logic [15:0]   cuenta_stall;

    control_buffer_filas #(.ANCHO(ANCHO), .ALTO(ALTO), .CW(CW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .inicio(inicio), .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready), .buf_full(buf_full), .buf_empty(buf_empty),
        .buf_write_req(buf_write_req), .buf_read_req(buf_read_req),
        .buf_clear(buf_clear), .sel_escritura(sel_escritura), .col(col),
        .fila(fila), .ventana_valida(ventana_valida), .fin_cuadro(fin_cuadro),
        .ocupado(ocupado), .cuenta_stall(cuenta_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 receiving pixels, 2 end-of-frame cycle.
    int m_fase, m_k, m_col, m_fila, m_stall;
    bit m_vv;
    // Expected and observed combinational values of the last cycle.
    bit       exp_ready, obs_ready, exp_sel_ok;
    bit [2:0] exp_wr, exp_rd, obs_wr, obs_rd;
    bit [1:0] exp_sel, obs_sel;

    task automatic modelo_reset();
        m_fase = 0; m_k = 0; m_col = 0; m_fila = 0; m_stall = 0; m_vv = 0;
    endtask

    task automatic arrancar();
        inicio = 1'b1; pixel_valid = 1'b0; buf_full = '0; buf_empty = '0;
        @(posedge clk); #1;
        inicio = 1'b0;
        m_fase = 1; m_k = 0; m_col = 0; m_fila = 0; m_stall = 0; m_vv = 0;
    endtask

    task automatic aplicar_reset();
        reset = 1'b1; inicio = 1'b0; pixel_valid = 1'b0; buf_full = '0; buf_empty = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        modelo_reset();
    endtask

    // Drives one clock cycle, records the combinational outputs and advances
    // the model to the expected post-edge state.
    task automatic ciclo(input bit v, input bit [2:0] ff, input bit [2:0] fe);
        int  fila_m, sel_m;
        bit  fl, acc;
        pixel_valid = v; buf_full = ff; buf_empty = fe;
        #3;
        fila_m = m_k / ANCHO;
        sel_m  = fila_m % 3;
        fl     = (m_k >= 2 * ANCHO);
        if (m_fase == 1)
            exp_ready = !ff[sel_m] && (!fl || (!fe[(sel_m + 1) % 3] && !fe[(sel_m + 2) % 3]));
        else
            exp_ready = 1'b0;
        acc        = v && exp_ready;
        exp_wr     = acc ? 3'(1 << sel_m) : 3'b000;
        exp_rd     = (acc && fl) ? 3'((1 << ((sel_m + 1) % 3)) | (1 << ((sel_m + 2) % 3))) : 3'b000;
        exp_sel    = 2'(sel_m);
        exp_sel_ok = (m_fase != 2);
        obs_ready  = pixel_ready;
        obs_wr     = buf_write_req;
        obs_rd     = buf_read_req;
        obs_sel    = sel_escritura;
`ifdef CTRL_FILAS_CONTADOR_STALL_EN
        if (m_fase != 0 && v && !exp_ready && m_stall < 65535) m_stall++;
`endif
        @(posedge clk); #1;
        m_vv = acc && fl;
        if (m_fase == 2) begin
            m_fase = 0; m_k = 0; m_col = 0; m_fila = 0;
        end else if (acc) begin
            m_col  = m_k % ANCHO;
            m_fila = m_k / ANCHO;
            m_k++;
            if (m_k == ANCHO * ALTO) m_fase = 2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; inicio = 1'b0; pixel_valid = 1'b0; buf_full = '0; buf_empty = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelo_reset();
        checks++; if (ocupado !== 1'b0) begin failures++; $display("FAIL rst_ocupado got=%b want=0", ocupado); end
        checks++; if (pixel_ready !== 1'b0 || buf_write_req !== 3'b000 || buf_read_req !== 3'b000 || buf_clear !== 1'b0) begin
            failures++; $display("FAIL rst_req got rdy=%b wr=%b rd=%b clr=%b want 0", pixel_ready, buf_write_req, buf_read_req, buf_clear); end
        checks++; if (sel_escritura !== 2'd0 || col !== '0 || fila !== '0) begin
            failures++; $display("FAIL rst_pos got sel=%0d col=%0d fila=%0d want 0", sel_escritura, col, fila); end
        checks++; if (ventana_valida !== 1'b0 || fin_cuadro !== 1'b0 || cuenta_stall !== 16'd0) begin
            failures++; $display("FAIL rst_flags got vv=%b fin=%b stall=%0d want 0", ventana_valida, fin_cuadro, cuenta_stall); end
        // inicio together with a pixel: the pixel must not be taken.
        inicio = 1'b1; pixel_valid = 1'b1;
        #3;
        checks++; if (pixel_ready !== 1'b0 || buf_write_req !== 3'b000) begin
            failures++; $display("FAIL inicio_pixel got rdy=%b wr=%b want 0/000", pixel_ready, buf_write_req); end
        @(posedge clk); #1;
        inicio = 1'b0; pixel_valid = 1'b0;
        m_fase = 1; m_k = 0;
        checks++; if (ocupado !== 1'b1 || col !== '0 || fila !== '0) begin
            failures++; $display("FAIL inicio_start got ocupado=%b col=%0d fila=%0d want 1/0/0", ocupado, col, fila); end
    endtask

    task automatic test_cebado();
        for (int i = 0; i < 8; i++) begin
            ciclo(1'b1, 3'b000, 3'b000);
            checks++; if (obs_wr !== ((i < 4) ? 3'b001 : 3'b010)) begin
                failures++; $display("FAIL cebado_wr px=%0d got=%b want=%b", i + 1, obs_wr, (i < 4) ? 3'b001 : 3'b010); end
            checks++; if (obs_rd !== 3'b000 || ventana_valida !== 1'b0) begin
                failures++; $display("FAIL cebado_rd px=%0d got rd=%b vv=%b want 000/0", i + 1, obs_rd, ventana_valida); end
        end
        ciclo(1'b1, 3'b000, 3'b000);
        checks++; if (obs_wr !== 3'b100 || obs_rd !== 3'b011) begin
            failures++; $display("FAIL px9_req got wr=%b rd=%b want 100/011", obs_wr, obs_rd); end
        checks++; if (ventana_valida !== 1'b1 || col !== 3'd0 || fila !== 3'd2) begin
            failures++; $display("FAIL px9_out got vv=%b col=%0d fila=%0d want 1/0/2", ventana_valida, col, fila); end
    endtask

    task automatic test_stall_flujo();
        ciclo(1'b1, 3'b100, 3'b000);
        checks++; if (obs_ready !== 1'b0 || obs_wr !== 3'b000 || obs_rd !== 3'b000) begin
            failures++; $display("FAIL stall_full got rdy=%b wr=%b rd=%b want 0/000/000", obs_ready, obs_wr, obs_rd); end
        checks++; if (col !== 3'd0 || fila !== 3'd2 || ventana_valida !== 1'b0) begin
            failures++; $display("FAIL stall_hold got col=%0d fila=%0d vv=%b want 0/2/0", col, fila, ventana_valida); end
        ciclo(1'b1, 3'b000, 3'b001);
        checks++; if (obs_ready !== 1'b0 || obs_rd !== 3'b000) begin
            failures++; $display("FAIL stall_empty got rdy=%b rd=%b want 0/000", obs_ready, obs_rd); end
        ciclo(1'b1, 3'b000, 3'b000);
        checks++; if (obs_ready !== 1'b1 || obs_wr !== 3'b100 || obs_rd !== 3'b011) begin
            failures++; $display("FAIL stall_resume got rdy=%b wr=%b rd=%b want 1/100/011", obs_ready, obs_wr, obs_rd); end
        checks++; if (col !== 3'd1 || fila !== 3'd2 || ventana_valida !== 1'b1) begin
            failures++; $display("FAIL stall_resume_pos got col=%0d fila=%0d vv=%b want 1/2/1", col, fila, ventana_valida); end
    endtask

    task automatic test_reset_medio();
        reset = 1'b1; pixel_valid = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        modelo_reset();
        checks++; if (ocupado !== 1'b0 || pixel_ready !== 1'b0 || buf_write_req !== 3'b000
                      || buf_read_req !== 3'b000 || buf_clear !== 1'b0 || fin_cuadro !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctl got ocu=%b rdy=%b wr=%b rd=%b clr=%b fin=%b want 0", ocupado,
                                 pixel_ready, buf_write_req, buf_read_req, buf_clear, fin_cuadro); end
        checks++; if (col !== '0 || fila !== '0 || sel_escritura !== 2'd0 || ventana_valida !== 1'b0 || cuenta_stall !== 16'd0) begin
            failures++; $display("FAIL rstmid_pos got col=%0d fila=%0d sel=%0d vv=%b stall=%0d want 0", col, fila,
                                 sel_escritura, ventana_valida, cuenta_stall); end
        arrancar();
        ciclo(1'b1, 3'b000, 3'b000);
        checks++; if (obs_wr !== 3'b001 || col !== 3'd0 || fila !== 3'd0) begin
            failures++; $display("FAIL rstmid_restart got wr=%b col=%0d fila=%0d want 001/0/0", obs_wr, col, fila); end
        ciclo(1'b1, 3'b000, 3'b000);
        checks++; if (col !== 3'd1 || fila !== 3'd0) begin
            failures++; $display("FAIL rstmid_next got col=%0d fila=%0d want 1/0", col, fila); end
    endtask

    task automatic test_frame_completo();
        int n = 0;
        int n_fin = 0;
        bit visto_fin = 1'b0;
        bit       v;
        bit [2:0] ff, fe;
        aplicar_reset();
        arrancar();
        while (!(visto_fin && m_fase == 0) && n < 400) begin
            v  = ($urandom_range(0, 3) != 0);
            ff = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            fe = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            ciclo(v, ff, fe);
            if (m_fase == 2) visto_fin = 1'b1;
            if (fin_cuadro === 1'b1) n_fin++;
            n++;
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL frm_ready cyc=%0d got=%b want=%b", n, obs_ready, exp_ready); end
            checks++; if (obs_wr !== exp_wr) begin failures++; $display("FAIL frm_wr cyc=%0d got=%b want=%b", n, obs_wr, exp_wr); end
            checks++; if (obs_rd !== exp_rd) begin failures++; $display("FAIL frm_rd cyc=%0d got=%b want=%b", n, obs_rd, exp_rd); end
            if (exp_sel_ok) begin
                checks++; if (obs_sel !== exp_sel) begin failures++; $display("FAIL frm_sel cyc=%0d got=%0d want=%0d", n, obs_sel, exp_sel); end
            end
            checks++; if (col !== 3'(m_col) || fila !== 3'(m_fila)) begin
                failures++; $display("FAIL frm_pos cyc=%0d got col=%0d fila=%0d want %0d/%0d", n, col, fila, m_col, m_fila); end
            checks++; if (ventana_valida !== m_vv) begin failures++; $display("FAIL frm_vv cyc=%0d got=%b want=%b", n, ventana_valida, m_vv); end
            checks++; if (fin_cuadro !== (m_fase == 2) || buf_clear !== (m_fase == 2)) begin
                failures++; $display("FAIL frm_fin cyc=%0d got fin=%b clr=%b want=%b", n, fin_cuadro, buf_clear, m_fase == 2); end
            checks++; if (ocupado !== (m_fase != 0)) begin failures++; $display("FAIL frm_ocupado cyc=%0d got=%b want=%b", n, ocupado, m_fase != 0); end
            checks++; if (cuenta_stall !== 16'(m_stall)) begin failures++; $display("FAIL frm_stall cyc=%0d got=%0d want=%0d", n, cuenta_stall, m_stall); end
        end
        checks++; if (!(visto_fin && m_fase == 0)) begin failures++; $display("FAIL frm_timeout got cycles=%0d want frame end", n); end
        checks++; if (n_fin !== 1) begin failures++; $display("FAIL frm_fin_count got=%0d want=1", n_fin); end
        checks++; if (sel_escritura !== 2'd0 || ocupado !== 1'b0) begin
            failures++; $display("FAIL frm_idle got sel=%0d ocupado=%b want 0/0", sel_escritura, ocupado); end
    endtask

    task automatic test_contador_stall();
        aplicar_reset();
        arrancar();
        for (int i = 0; i < 5; i++) begin
            ciclo(1'b1, 3'b001, 3'b000);
            checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL cnt_ready cyc=%0d got=%b want=0", i, obs_ready); end
        end
`ifdef CTRL_FILAS_CONTADOR_STALL_EN
        checks++; if (cuenta_stall !== 16'd5) begin failures++; $display("FAIL cnt_stall got=%0d want=5", cuenta_stall); end
`else
        checks++; if (cuenta_stall !== 16'd0) begin failures++; $display("FAIL cnt_stall got=%0d want=0", cuenta_stall); end
`endif
        ciclo(1'b1, 3'b000, 3'b000);
        checks++; if (obs_wr !== 3'b001 || col !== 3'd0) begin
            failures++; $display("FAIL cnt_resume got wr=%b col=%0d want 001/0", obs_wr, col); end
    endtask

    initial begin
        reset = 1'b1; inicio = 1'b0; pixel_valid = 1'b0; buf_full = '0; buf_empty = '0;
        modelo_reset();
        test_reset();
        test_cebado();
        test_stall_flujo();
        test_reset_medio();
        test_frame_completo();
        test_contador_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
